// File: rtl/adc_scan_pkg.sv
// ---------------------------------------------------------------------------
// adc_scan_pkg
// Shared definitions for the SAR scan sequencer (adc_scan_ctl):
//   - default timing/width constants used as parameter defaults
//   - analog mux channel indices (bit positions of the CMP_SEL_* vector)
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package adc_scan_pkg;

    localparam int NCH_DEF    = 16;  // mux channels
    localparam int DACW_DEF   = 10;  // SAR DAC code width
    localparam int SH_CYC_DEF = 4;   // track cycles after S/H reset
    localparam int SETTLE_DEF = 2;   // cycles per bit trial

    localparam int CH_VIN   = 0;
    localparam int CH_VBUS  = 1;
    localparam int CH_IS    = 2;
    localparam int CH_T     = 3;
    localparam int CH_DP    = 4;
    localparam int CH_DN    = 5;
    localparam int CH_CC1   = 6;
    localparam int CH_CC2   = 7;
    localparam int CH_DV    = 8;
    localparam int CH_DI    = 9;
    localparam int CH_VIN20 = 10;
    localparam int CH_CC1_4 = 11;
    localparam int CH_CC2_4 = 12;
    localparam int CH_GP5   = 13;
    localparam int CH_GP4   = 14;
    localparam int CH_GP3   = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_SAMP = 3'd2,
        ST_CONV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/adc_scan_ctl_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin priority encoder. Searches req upward starting
// at ptr+1 (wrapping) and returns the index of the first set bit.
// Ports:
//   req     in  NCH  request vector
//   ptr     in  IW   index granted last time (lowest priority now)
//   gnt_idx out IW   granted index (0 when nothing requested)
//   gnt_vld out 1    any request present
// ---------------------------------------------------------------------------
module rr_arb #(
    parameter int NCH = 16,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  gnt_idx,
    output logic           gnt_vld
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset to the nearest so the nearest set bit
    // after ptr is the one left standing.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int off = NCH; off >= 1; off--) begin
            cand = IW'((int'(ptr) + off) % NCH);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctl.sv
// ---------------------------------------------------------------------------
// adc_scan_ctl
// Core-side sequencer for the shared SAR comparator/DAC path. Picks a
// requested channel round-robin, drives the one-hot mux select and the
// sample/hold controls, runs a successive approximation on the DAC1 code
// from the comparator output and posts one result per conversion.
//
// Build option: define ADC_OVS_EN to run two RST/SAMP/CONV passes per grant
// and report the rounded average of both codes.
//
// Ports:
//   clk      in   core clock
//   rstz     in   asynchronous active-low reset
//   scan_en  in   scan enable (level)
//   ch_req   in   NCH channels included in the scan
//   abort    in   synchronous abort of the current conversion
//   comp_i   in   comparator output, 1 = input >= DAC code
//   dac_en   out  DAC1_EN
//   dac_sel  out  NCH one-hot comparator mux select
//   sh_rst   out  AD_RST
//   sh_hold  out  AD_HOLD
//   dac_code out  DACW DAC1 code
//   busy     out  sequencer not idle
//   res_vld  out  one-cycle result strobe
//   res_ch   out  4-bit channel index of result
//   res_dat  out  DACW conversion result
// ---------------------------------------------------------------------------
module adc_scan_ctl
    import adc_scan_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int DACW   = DACW_DEF,
    parameter int SH_CYC = SH_CYC_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rstz,
    input  logic            scan_en,
    input  logic [NCH-1:0]  ch_req,
    input  logic            abort,
    input  logic            comp_i,
    output logic            dac_en,
    output logic [NCH-1:0]  dac_sel,
    output logic            sh_rst,
    output logic            sh_hold,
    output logic [DACW-1:0] dac_code,
    output logic            busy,
    output logic            res_vld,
    output logic [3:0]      res_ch,
    output logic [DACW-1:0] res_dat
);

    localparam int IW   = $clog2(NCH);
    localparam int BW   = $clog2(DACW);
    localparam int CMAX = (SH_CYC > SETTLE) ? SH_CYC : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DACW-1:0] code_q, code_d;
    logic [DACW-1:0] res_dat_q, res_dat_d;
    logic [3:0]      res_ch_q, res_ch_d;
    logic [DACW-1:0] result;
    logic            done_post;
`ifdef ADC_OVS_EN
    logic            pass_q, pass_d;
    logic [DACW-1:0] r0_q, r0_d;
    logic [DACW:0]   sum;
`endif

    rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req     (ch_req),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // abort wins over a DONE in the same cycle: nothing is posted
    assign done_post = (state_q == ST_DONE) && !abort;

`ifdef ADC_OVS_EN
    // One extra bit keeps the sum of two full-scale codes plus rounding
    assign sum    = {1'b0, r0_q} + {1'b0, code_q} + {{DACW{1'b0}}, 1'b1};
    assign result = sum[DACW:1];
`else
    assign result = code_q;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        code_d    = code_q;
        res_dat_d = res_dat_q;
        res_ch_d  = res_ch_q;
`ifdef ADC_OVS_EN
        pass_d    = pass_q;
        r0_d      = r0_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (scan_en && gnt_vld) begin
                    idx_d   = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = ST_RST;
`ifdef ADC_OVS_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            ST_RST: begin
                cnt_d   = '0;
                state_d = ST_SAMP;
            end
            ST_SAMP: begin
                if (cnt_q == CW'(SH_CYC - 1)) begin
                    cnt_d            = '0;
                    bit_d            = BW'(DACW - 1);
                    code_d           = '0;
                    code_d[DACW - 1] = 1'b1;
                    state_d          = ST_CONV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONV: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    // Decide the bit under trial, then stage the next trial bit
                    cnt_d = '0;
                    if (!comp_i) begin
                        code_d[bit_q] = 1'b0;
                    end
                    if (bit_q != '0) begin
                        code_d[bit_q - 1'b1] = 1'b1;
                        bit_d                = bit_q - 1'b1;
                    end else begin
`ifdef ADC_OVS_EN
                        if (!pass_q) begin
                            pass_d  = 1'b1;
                            r0_d    = code_d;
                            state_d = ST_RST;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (done_post) begin
                    res_dat_d = result;
                    res_ch_d  = 4'(idx_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= IW'(NCH - 1);
            cnt_q     <= '0;
            bit_q     <= '0;
            code_q    <= '0;
            res_dat_q <= '0;
            res_ch_q  <= '0;
`ifdef ADC_OVS_EN
            pass_q    <= 1'b0;
            r0_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            code_q    <= code_d;
            res_dat_q <= res_dat_d;
            res_ch_q  <= res_ch_d;
`ifdef ADC_OVS_EN
            pass_q    <= pass_d;
            r0_q      <= r0_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign dac_en   = (state_q == ST_RST) || (state_q == ST_SAMP) || (state_q == ST_CONV);
    assign dac_sel  = dac_en ? (NCH'(1) << idx_q) : '0;
    assign sh_rst   = (state_q == ST_RST);
    assign sh_hold  = (state_q == ST_CONV);
    assign dac_code = sh_hold ? code_q : '0;

    // Result is visible during the DONE strobe and held afterwards
    assign res_vld  = done_post;
    assign res_ch   = done_post ? 4'(idx_q) : res_ch_q;
    assign res_dat  = done_post ? result : res_dat_q;

endmodule
